// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell; d/bout update only when done pulses.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nx;
   logic             br;
   logic             br_nx;
   logic             diff;
   logic [CW-1:0]    cnt;
   logic             last_bit;

   // Full-subtractor cell on the current LSBs of the operand shift registers.
   assign diff     = a_sr[0] ^ b_sr[0] ^ br;
   assign br_nx    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
   assign res_nx   = {diff, res[WIDTH-1:1]};
   assign last_bit = (cnt == CW'(WIDTH - 1));

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last_bit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr <= '0;
         b_sr <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         d    <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  br   <= bin;
                  res  <= '0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               br   <= br_nx;
               res  <= res_nx;
               // Counter saturates on the final bit instead of wrapping.
               if (!last_bit) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  d    <= res_nx;
                  bout <= br_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: driver issues operations and queues expected
// {bout,d}; a negedge monitor checks every done pulse and the held outputs.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;

   logic [WIDTH:0] exp_q[$];
   int             issue_q[$];

   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   int             busy_run = 0;
   int             last_done_cyc = 0;
   bit             b2b = 1'b0;
   logic [WIDTH:0] held = '0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .d    (d),
      .bout (bout)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, actual, required, cyc);
      end
   endtask

   // Driver tasks: inputs change 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ibin, input bit push, input logic [WIDTH:0] expv);
      a     = ia;
      b     = ib;
      bin   = ibin;
      start = 1'b1;
      if (push) begin
         exp_q.push_back(expv);
         issue_q.push_back(cyc);
      end
      tick();
      start = 1'b0;
      a     = WIDTH'($urandom_range(0, 255));
      b     = WIDTH'($urandom_range(0, 255));
      bin   = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 4 * WIDTH) begin
         tick();
         n++;
      end
      check("done_timeout", int'(done === 1'b1), 1);
      tick();
   endtask

   task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                     input logic ibin, input logic [WIDTH:0] expv);
      issue(ia, ib, ibin, 1'b1, expv);
      wait_done();
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [WIDTH:0] e;
      if (done === 1'b1) begin
         check("busy_with_done", int'(busy), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            int ic;
            e  = exp_q.pop_front();
            ic = issue_q.pop_front();
            check("result", int'({bout, d}), int'(e));
            check("latency", cyc - ic - 1, WIDTH);
            check("busy_cycles", busy_run, WIDTH);
            if (b2b) check("done_spacing", cyc - last_done_cyc, WIDTH + 2);
            held = e;
         end
         last_done_cyc = cyc;
         busy_run = 0;
      end else begin
         if ({bout, d} !== held) check("held_output", int'({bout, d}), int'(held));
         if (busy === 1'b1) busy_run++;
      end
      // Reset applies at the next edge, so expectations follow it from then on.
      if (rst === 1'b1) begin
         held     = '0;
         busy_run = 0;
      end
   end

   // Stimulus
   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rbin;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_d", int'(d), 0);
      check("reset_bout", int'(bout), 0);

      // Directed vectors, the first one issued on the first edge with rst=0.
      op(8'h05, 8'h03, 1'b0, 9'h002);
      op(8'h03, 8'h05, 1'b0, 9'h1FE);
      op(8'h00, 8'h00, 1'b1, 9'h1FF);
      op(8'hFF, 8'hFF, 1'b0, 9'h000);
      op(8'h00, 8'h01, 1'b1, 9'h1FE);
      op(8'h80, 8'h7F, 1'b1, 9'h000);

      // A start pulse mid-operation must be ignored.
      issue(8'h10, 8'h01, 1'b0, 1'b1, 9'h00F);
      tick();
      tick();
      a     = 8'h00;
      b     = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = 8'h33;
      b     = 8'h44;
      wait_done();
      repeat (2 * WIDTH) tick();
      check("queue_after_ignored_start", exp_q.size(), 0);

      // Reset in the middle of an operation aborts it.
      issue(8'h80, 8'h01, 1'b0, 1'b0, '0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_d", int'(d), 0);
      check("abort_bout", int'(bout), 0);
      repeat (2 * WIDTH) tick();
      op(8'h05, 8'h03, 1'b1, 9'h001);

      // Randomised back-to-back operations against a 9-bit difference model.
      for (int i = 0; i < 1000; i++) begin
         ra   = WIDTH'($urandom_range(0, 255));
         rb   = WIDTH'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         if (i == 1) b2b = 1'b1;
         op(ra, rb, rbin, {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin});
      end
      b2b = 1'b0;

      repeat (4) tick();
      check("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
